operand_issue: RTL and testbench

OPERAND_ISSUE -- requirements
Module: operand_issue

---
 rtl/operand_issue_pkg.sv | 13 +
 rtl/operand_issue_reg_file.sv | 29 ++
 rtl/operand_issue.sv | 115 +++++++++++
 tb/tb_operand_issue.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/operand_issue_pkg.sv
// operand_issue_pkg: shared data, opcode and register-address types for the operand issue stage.
package operand_issue_pkg;
    localparam int DATA_W      = 8;
    localparam int ALU_OP_AMT  = 8;
    localparam int REG_AMT_DEF = 8;

    typedef logic [DATA_W-1:0] t_data;
    typedef logic [$clog2(REG_AMT_DEF)-1:0] t_reg_addr;

    typedef enum logic [$clog2(ALU_OP_AMT)-1:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_PASS
    } t_opcode;
endpackage

// File: rtl/operand_issue_reg_file.sv
// reg_file: general registers with two async read ports and one sync write port; R0 is hardwired to 0.
module reg_file
    import operand_issue_pkg::*;
#(
    parameter int REG_AMT = REG_AMT_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [$clog2(REG_AMT)-1:0] raddr0_i,
    input  logic [$clog2(REG_AMT)-1:0] raddr1_i,
    output t_data                      rdata0_o,
    output t_data                      rdata1_o,
    input  logic                       we_i,
    input  logic [$clog2(REG_AMT)-1:0] waddr_i,
    input  t_data                      wdata_i
);
    t_data regs_q [REG_AMT];

    assign rdata0_o = (raddr0_i == '0) ? '0 : regs_q[raddr0_i];
    assign rdata1_o = (raddr1_i == '0) ? '0 : regs_q[raddr1_i];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_AMT; i++) regs_q[i] <= '0;
        end else if (we_i && waddr_i != '0) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end
endmodule

// File: rtl/operand_issue.sv
// operand_issue: reads/forwards ALU operands, stalls on load-use hazards and registers
// the issued operands behind a valid/ready output stage.
module operand_issue
    import operand_issue_pkg::*;
#(
    parameter int REG_AMT = REG_AMT_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  t_opcode                    in_op,
    input  logic [$clog2(REG_AMT)-1:0] in_rd,
    input  logic [$clog2(REG_AMT)-1:0] in_rs1,
    input  logic [$clog2(REG_AMT)-1:0] in_rs2,
    input  t_data                      in_imm,
    input  logic                       in_use_imm,
    input  logic                       in_wr_en,
    input  logic                       ex_wr_en,
    input  logic [$clog2(REG_AMT)-1:0] ex_rd,
    input  t_data                      ex_result,
    input  logic                       ex_is_load,
    input  logic                       wb_en,
    input  logic [$clog2(REG_AMT)-1:0] wb_rd,
    input  t_data                      wb_data,
    input  logic                       flush,
    input  logic                       out_ready,
    output logic                       out_valid,
    output t_data                      A,
    output t_data                      B,
    output t_opcode                    op,
    output logic [$clog2(REG_AMT)-1:0] out_rd,
    output logic                       out_wr_en
);
    localparam int AW = $clog2(REG_AMT);

    t_data rf_rs1, rf_rs2, rs1_val, rs2_val;
    logic ex_fwd_ok, hazard, load_en, accept;
    logic out_valid_q, out_valid_d, out_wr_en_q, out_wr_en_d;
    t_data a_q, a_d, b_q, b_d;
    t_opcode op_q, op_d;
    logic [AW-1:0] rd_q, rd_d;

    reg_file #(.REG_AMT(REG_AMT)) u_reg_file (
        .clk      (clk),
        .rst_n    (rst_n),
        .raddr0_i (in_rs1),
        .raddr1_i (in_rs2),
        .rdata0_o (rf_rs1),
        .rdata1_o (rf_rs2),
        .we_i     (wb_en),
        .waddr_i  (wb_rd),
        .wdata_i  (wb_data)
    );

    // A load in EX has no result yet, so it can only be covered by stalling.
    assign ex_fwd_ok = ex_wr_en && !ex_is_load;
    assign rs1_val = (in_rs1 == '0) ? '0 :
                     (ex_fwd_ok && ex_rd == in_rs1) ? ex_result :
                     (wb_en && wb_rd == in_rs1) ? wb_data : rf_rs1;
    assign rs2_val = (in_rs2 == '0) ? '0 :
                     (ex_fwd_ok && ex_rd == in_rs2) ? ex_result :
                     (wb_en && wb_rd == in_rs2) ? wb_data : rf_rs2;

    assign hazard = in_valid && ex_is_load && ex_wr_en && ex_rd != '0 &&
                    (ex_rd == in_rs1 || (!in_use_imm && ex_rd == in_rs2));
    assign load_en  = !out_valid_q || out_ready;
    assign in_ready = rst_n && load_en && !hazard && !flush;
    assign accept   = in_valid && in_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        out_wr_en_d = out_wr_en_q;
        a_d = a_q;
        b_d = b_q;
        op_d = op_q;
        rd_d = rd_q;
        if (flush) begin
            out_valid_d = 1'b0;
            out_wr_en_d = 1'b0;
        end else if (load_en) begin
            out_valid_d = accept;
            out_wr_en_d = accept && in_wr_en;
            a_d = rs1_val;
            b_d = in_use_imm ? in_imm : rs2_val;
            op_d = in_op;
            rd_d = in_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_wr_en_q <= 1'b0;
            a_q <= '0;
            b_q <= '0;
            op_q <= op_q.first();
            rd_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_wr_en_q <= out_wr_en_d;
            a_q <= a_d;
            b_q <= b_d;
            op_q <= op_d;
            rd_q <= rd_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_wr_en = out_wr_en_q;
    assign A = a_q;
    assign B = b_q;
    assign op = op_q;
    assign out_rd = rd_q;
endmodule

// File: tb/tb_operand_issue.sv
// tb_operand_issue: directed scenarios plus randomized traffic checked against a
// cycle-level reference model of the operand issue stage.
module tb_operand_issue;
    import operand_issue_pkg::*;

    logic clk = 1'b0;
    logic rst_n, in_valid, in_ready, in_use_imm, in_wr_en;
    t_opcode in_op, op;
    logic [2:0] in_rd, in_rs1, in_rs2, ex_rd, wb_rd, out_rd;
    t_data in_imm, ex_result, wb_data, A, B;
    logic ex_wr_en, ex_is_load, wb_en, flush, out_ready, out_valid, out_wr_en;

    int errors = 0;
    int checks = 0;

    bit      e_valid = 0, e_wr = 0;
    t_data   e_a = 0, e_b = 0;
    t_opcode e_op = OP_ADD;
    bit [2:0] e_rd = 0;
    t_data   mrf [8];

    always #5 clk = ~clk;

    operand_issue #(.REG_AMT(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_imm(in_imm), .in_use_imm(in_use_imm), .in_wr_en(in_wr_en),
        .ex_wr_en(ex_wr_en), .ex_rd(ex_rd), .ex_result(ex_result), .ex_is_load(ex_is_load),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
        .out_ready(out_ready), .out_valid(out_valid), .A(A), .B(B), .op(op),
        .out_rd(out_rd), .out_wr_en(out_wr_en)
    );

    // Architectural value of a register as seen by an instruction issuing this cycle.
    function automatic t_data reg_view(input logic [2:0] rs);
        if (rs == 0) return '0;
        if (ex_wr_en && !ex_is_load && ex_rd == rs) return ex_result;
        if (wb_en && wb_rd == rs) return wb_data;
        return mrf[rs];
    endfunction

    task automatic idle();
        rst_n = 1; in_valid = 0; in_op = OP_ADD; in_rd = 0; in_rs1 = 0; in_rs2 = 0;
        in_imm = 0; in_use_imm = 0; in_wr_en = 0; ex_wr_en = 0; ex_rd = 0;
        ex_result = 0; ex_is_load = 0; wb_en = 0; wb_rd = 0; wb_data = 0;
        flush = 0; out_ready = 1;
    endtask

    // One clock: check in_ready, advance the model, check the registered outputs.
    task automatic tick(input string tag);
        bit hz, rdy;
        t_data va, vb;
        #1;
        hz = in_valid && ex_is_load && ex_wr_en && ex_rd != 0 &&
             (ex_rd == in_rs1 || (!in_use_imm && ex_rd == in_rs2));
        rdy = rst_n && (!e_valid || out_ready) && !hz && !flush;
        va = reg_view(in_rs1);
        vb = in_use_imm ? in_imm : reg_view(in_rs2);
        checks++;
        if (in_ready !== rdy) begin
            errors++;
            $display("FAIL %s in_ready: got %b expected %b", tag, in_ready, rdy);
        end
        @(posedge clk);
        #1;
        if (!rst_n) begin
            e_valid = 0; e_wr = 0; e_a = 0; e_b = 0; e_op = OP_ADD; e_rd = 0;
            foreach (mrf[i]) mrf[i] = 0;
        end else begin
            if (flush) begin
                e_valid = 0; e_wr = 0;
            end else if (!e_valid || out_ready) begin
                e_valid = in_valid && rdy;
                e_wr = e_valid && in_wr_en;
                e_a = va; e_b = vb; e_op = in_op; e_rd = in_rd;
            end
            if (wb_en && wb_rd != 0) mrf[wb_rd] = wb_data;
        end
        checks++;
        if (out_valid !== e_valid || out_wr_en !== e_wr) begin
            errors++;
            $display("FAIL %s valid/wr_en: got %b/%b expected %b/%b", tag, out_valid, out_wr_en, e_valid, e_wr);
        end
        if (e_valid) begin
            checks++;
            if (A !== e_a || B !== e_b || op !== e_op || out_rd !== e_rd) begin
                errors++;
                $display("FAIL %s operands: got A=%h B=%h op=%0d rd=%0d expected A=%h B=%h op=%0d rd=%0d",
                         tag, A, B, op, out_rd, e_a, e_b, e_op, e_rd);
            end
        end
    endtask

    task automatic test_reset();
        idle();
        rst_n = 0; in_valid = 1;
        tick("reset0");
        tick("reset1");
        checks++;
        if (out_valid !== 0 || A !== 0 || B !== 0 || op !== OP_ADD || out_wr_en !== 0) begin
            errors++;
            $display("FAIL reset_state: got v=%b A=%h B=%h op=%0d wr=%b expected 0/0/0/0/0", out_valid, A, B, op, out_wr_en);
        end
        checks++;
        if (in_ready !== 0) begin
            errors++;
            $display("FAIL reset_in_ready: got %b expected 0", in_ready);
        end
        idle();
        tick("reset_release");
    endtask

    task automatic test_wb_read();
        idle();
        wb_en = 1; wb_rd = 3; wb_data = 8'd16;
        tick("wb_write");
        idle();
        in_valid = 1; in_rs1 = 3; in_rs2 = 0; in_use_imm = 1; in_imm = 8'd15; in_op = OP_SUB; in_rd = 5; in_wr_en = 1;
        tick("wb_read");
        checks++;
        if (out_valid !== 1 || A !== 8'd16 || B !== 8'd15 || out_wr_en !== 1) begin
            errors++;
            $display("FAIL wb_read: got v=%b A=%0d B=%0d wr=%b expected 1/16/15/1", out_valid, A, B, out_wr_en);
        end
    endtask

    task automatic test_ex_forward();
        idle();
        ex_wr_en = 1; ex_rd = 2; ex_result = 8'h2A; wb_en = 1; wb_rd = 2; wb_data = 8'd7;
        in_valid = 1; in_rs1 = 2; in_rs2 = 2; in_op = OP_AND;
        tick("ex_fwd");
        checks++;
        if (A !== 8'h2A || B !== 8'h2A) begin
            errors++;
            $display("FAIL ex_forward: got A=%h B=%h expected 2a/2a", A, B);
        end
        idle();
        in_valid = 1; in_rs1 = 2;
        tick("ex_fwd_after");
        checks++;
        if (A !== 8'd7) begin
            errors++;
            $display("FAIL wb_committed: got A=%h expected 07", A);
        end
    endtask

    task automatic test_load_use();
        idle();
        ex_is_load = 1; ex_wr_en = 1; ex_rd = 4;
        in_valid = 1; in_rs1 = 0; in_rs2 = 4; in_use_imm = 0; in_op = OP_XOR; in_wr_en = 1; in_rd = 6;
        #1;
        checks++;
        if (in_ready !== 0) begin
            errors++;
            $display("FAIL load_use_stall: got in_ready=%b expected 0", in_ready);
        end
        tick("load_use_bubble");
        checks++;
        if (out_valid !== 0 || out_wr_en !== 0) begin
            errors++;
            $display("FAIL load_use_bubble: got v=%b wr=%b expected 0/0", out_valid, out_wr_en);
        end
        ex_is_load = 0; ex_wr_en = 0; wb_en = 1; wb_rd = 4; wb_data = 8'd9;
        tick("load_use_issue");
        checks++;
        if (out_valid !== 1 || B !== 8'd9) begin
            errors++;
            $display("FAIL load_use_issue: got v=%b B=%0d expected 1/9", out_valid, B);
        end
    endtask

    task automatic test_backpressure();
        t_data sa, sb;
        idle();
        in_valid = 1; in_use_imm = 1; in_imm = 8'h11; in_rs1 = 4; in_op = OP_OR; in_rd = 1; in_wr_en = 1;
        tick("bp_first");
        sa = A; sb = B;
        out_ready = 0; in_imm = 8'h77; in_op = OP_SLL; in_rd = 2;
        for (int i = 0; i < 3; i++) begin
            tick("bp_hold");
            checks++;
            if (out_valid !== 1 || A !== sa || B !== sb || op !== OP_OR || out_rd !== 1) begin
                errors++;
                $display("FAIL bp_hold: got v=%b A=%h B=%h op=%0d rd=%0d expected 1/%h/%h/%0d/1", out_valid, A, B, op, out_rd, sa, sb, OP_OR);
            end
        end
        out_ready = 1;
        tick("bp_release");
        checks++;
        if (out_valid !== 1 || B !== 8'h77 || op !== OP_SLL || out_rd !== 2) begin
            errors++;
            $display("FAIL bp_release: got v=%b B=%h op=%0d rd=%0d expected 1/77/%0d/2", out_valid, B, op, out_rd, OP_SLL);
        end
    endtask

    task automatic test_flush_r0();
        idle();
        in_valid = 1; in_rs1 = 3; in_wr_en = 1; in_rd = 3;
        tick("flush_fill");
        out_ready = 0; flush = 1; wb_en = 1; wb_rd = 0; wb_data = 8'd5;
        tick("flush");
        checks++;
        if (out_valid !== 0 || out_wr_en !== 0) begin
            errors++;
            $display("FAIL flush: got v=%b wr=%b expected 0/0", out_valid, out_wr_en);
        end
        idle();
        in_valid = 1; in_rs1 = 0; in_rs2 = 0;
        tick("r0_read");
        checks++;
        if (out_valid !== 1 || A !== 0 || B !== 0) begin
            errors++;
            $display("FAIL r0_read: got v=%b A=%h B=%h expected 1/00/00", out_valid, A, B);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            rst_n      = ($urandom_range(0, 59) != 0);
            in_valid   = ($urandom_range(0, 3) != 0);
            in_op      = t_opcode'($urandom_range(0, ALU_OP_AMT - 1));
            in_rd      = 3'($urandom_range(0, 7));
            in_rs1     = 3'($urandom_range(0, 7));
            in_rs2     = 3'($urandom_range(0, 7));
            in_imm     = t_data'($urandom);
            in_use_imm = $urandom_range(0, 2) == 0;
            in_wr_en   = $urandom_range(0, 1) == 1;
            ex_wr_en   = $urandom_range(0, 1) == 1;
            ex_rd      = 3'($urandom_range(0, 7));
            ex_result  = t_data'($urandom);
            ex_is_load = $urandom_range(0, 2) == 0;
            wb_en      = $urandom_range(0, 1) == 1;
            wb_rd      = 3'($urandom_range(0, 7));
            wb_data    = t_data'($urandom);
            flush      = $urandom_range(0, 11) == 0;
            out_ready  = $urandom_range(0, 9) < 7;
            tick("random");
        end
    endtask

    initial begin
        foreach (mrf[i]) mrf[i] = 0;
        test_reset();
        test_wb_read();
        test_ex_forward();
        test_load_use();
        test_backpressure();
        test_flush_r0();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
